// File: rtl/tl_rom_device_pkg.sv
// rtl/tl_rom_device_pkg.sv - TL-UH channel types and burst helpers for the ROM device
package tl_rom_device_pkg;

  localparam int unsigned TlDataW   = 64;
  localparam int unsigned TlAddrW   = 56;
  localparam int unsigned TlSourceW = 1;
  localparam int unsigned TlSinkW   = 1;
  localparam int unsigned TlSizeW   = 4;

  typedef enum logic [2:0] {
    PutFullData    = 3'd0,
    PutPartialData = 3'd1,
    ArithmeticData = 3'd2,
    LogicalData    = 3'd3,
    Get            = 3'd4,
    Intent         = 3'd5
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'd0,
    AccessAckData = 3'd1,
    HintAck       = 3'd2
  } tl_d_op_e;

  typedef struct packed {
    tl_a_op_e                opcode;
    logic [2:0]              param;
    logic [TlSizeW-1:0]      size;
    logic [TlSourceW-1:0]    source;
    logic [TlAddrW-1:0]      address;
    logic [TlDataW/8-1:0]    mask;
    logic [TlDataW-1:0]      data;
    logic                    corrupt;
  } tl_a_t;

  typedef struct packed {
    tl_d_op_e                opcode;
    logic [1:0]              param;
    logic [TlSizeW-1:0]      size;
    logic [TlSourceW-1:0]    source;
    logic [TlSinkW-1:0]      sink;
    logic                    denied;
    logic [TlDataW-1:0]      data;
    logic                    corrupt;
  } tl_d_t;

  // Number of data beats for a transfer of 2^size bytes; sizes above max_size are clamped.
  function automatic logic [15:0] beat_count(input logic [TlSizeW-1:0] size,
                                             input int unsigned beat_bits,
                                             input int unsigned max_size);
    int unsigned s;
    s = (32'(size) > max_size) ? max_size : 32'(size);
    if (s <= beat_bits) return 16'd1;
    return 16'(32'd1 << (s - beat_bits));
  endfunction

endpackage

// File: rtl/tl_rom_device.sv
// rtl/tl_rom_device.sv - TL-UH ROM endpoint: serves Get bursts from a 1-cycle ROM, denies writes and atomics
module tl_rom_device
  import tl_rom_device_pkg::*;
#(
  parameter int unsigned          DataWidth   = TlDataW,
  parameter int unsigned          AddrWidth   = TlAddrW,
  parameter int unsigned          SourceWidth = TlSourceW,
  parameter int unsigned          SinkWidth   = TlSinkW,
  parameter int unsigned          MaxSize     = 6,
  parameter logic [AddrWidth-1:0] RomBase     = '0,
  parameter int unsigned          RomDepth    = 1024,
  localparam int unsigned         RomIdxW     = $clog2(RomDepth)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 host_a_valid_i,
  input  tl_a_t                host_a_i,
  output logic                 host_a_ready_o,
  output logic                 host_d_valid_o,
  output tl_d_t                host_d_o,
  input  logic                 host_d_ready_i,
  output logic                 host_b_valid_o,
  output logic                 host_c_ready_o,
  output logic                 host_e_ready_o,
  output logic                 rom_req_o,
  output logic [RomIdxW-1:0]   rom_addr_o,
  input  logic [DataWidth-1:0] rom_rdata_i
);

  localparam int unsigned BeatBytes = DataWidth / 8;
  localparam int unsigned BeatBits  = $clog2(BeatBytes);
  localparam int unsigned MaxBeats  = (MaxSize > BeatBits) ? (32'd1 << (MaxSize - BeatBits)) : 32'd1;
  localparam int unsigned CntW      = $clog2(MaxBeats) + 1;
  localparam logic [AddrWidth:0] RomEnd = {1'b0, RomBase} + (AddrWidth+1)'(RomDepth * BeatBytes);

  typedef enum logic [1:0] {StIdle, StDrain, StResp} state_e;

  state_e                 state_q, state_d;
  tl_d_op_e               d_op_q, d_op_d;
  logic [TlSizeW-1:0]     size_q, size_d;
  logic [SourceWidth-1:0] source_q, source_d;
  logic                   denied_q, denied_d;
  logic                   corrupt_q, corrupt_d;
  logic                   rom_backed_q, rom_backed_d;
  logic [CntW-1:0]        beats_q, beats_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [CntW-1:0]        drain_q, drain_d;
  logic [RomIdxW-1:0]     start_q, start_d;
  logic [RomIdxW-1:0]     mask_q, mask_d;
  logic                   hold_valid_q, hold_valid_d;
  logic [DataWidth-1:0]   hold_q, hold_d;

  logic                   a_fire, d_fire, last_beat, multi_a;
  logic [CntW-1:0]        n_a, cnt_nxt;
  logic [AddrWidth-1:0]   align_mask, aligned, offset;
  logic [RomIdxW-1:0]     start_idx_a, next_idx;
  logic                   in_range;
  logic                   unused_a;

  assign host_b_valid_o = 1'b0;
  assign host_c_ready_o = 1'b1;
  assign host_e_ready_o = 1'b1;

  // Handshake qualifiers are gated by reset so nothing is accepted or shown mid-reset.
  assign host_a_ready_o = !rst_i && (state_q == StIdle || state_q == StDrain);
  assign host_d_valid_o = !rst_i && (state_q == StResp);
  assign a_fire         = host_a_valid_i && host_a_ready_o;
  assign d_fire         = host_d_valid_o && host_d_ready_i;

  assign n_a         = CntW'(beat_count(host_a_i.size, BeatBits, MaxSize));
  assign multi_a     = (n_a != CntW'(1));
  assign align_mask  = ~((AddrWidth'(1) << host_a_i.size) - AddrWidth'(1));
  assign aligned     = host_a_i.address & align_mask;
  assign offset      = aligned - RomBase;
  assign start_idx_a = RomIdxW'(offset >> BeatBits);
  assign in_range    = ({1'b0, host_a_i.address} >= {1'b0, RomBase}) &&
                       ({1'b0, host_a_i.address} < RomEnd);

  assign last_beat = (cnt_q == beats_q - CntW'(1));
  assign cnt_nxt   = cnt_q + CntW'(1);
  // Word index stays inside the naturally aligned block of the burst.
  assign next_idx  = (start_q & ~mask_q) | ((start_q + RomIdxW'(cnt_nxt)) & mask_q);

  assign unused_a = ^{host_a_i.param, host_a_i.mask, host_a_i.data, host_a_i.corrupt};

  always_comb begin
    host_d_o         = '0;
    host_d_o.opcode  = d_op_q;
    host_d_o.param   = 2'b00;
    host_d_o.size    = size_q;
    host_d_o.source  = source_q;
    host_d_o.sink    = {SinkWidth{1'b0}};
    host_d_o.denied  = denied_q;
    host_d_o.corrupt = corrupt_q;
    host_d_o.data    = rom_backed_q ? (hold_valid_q ? hold_q : rom_rdata_i) : '0;
  end

  always_comb begin
    state_d      = state_q;
    d_op_d       = d_op_q;
    size_d       = size_q;
    source_d     = source_q;
    denied_d     = denied_q;
    corrupt_d    = corrupt_q;
    rom_backed_d = rom_backed_q;
    beats_d      = beats_q;
    cnt_d        = cnt_q;
    drain_d      = drain_q;
    start_d      = start_q;
    mask_d       = mask_q;
    hold_valid_d = hold_valid_q;
    hold_d       = hold_q;
    rom_req_o    = 1'b0;
    rom_addr_o   = 'x;

    unique case (state_q)
      StIdle: begin
        if (a_fire) begin
          size_d       = host_a_i.size;
          source_d     = host_a_i.source;
          beats_d      = n_a;
          cnt_d        = '0;
          drain_d      = n_a - CntW'(1);
          start_d      = start_idx_a;
          mask_d       = RomIdxW'(n_a - CntW'(1));
          hold_valid_d = 1'b0;
          denied_d     = 1'b1;
          corrupt_d    = 1'b0;
          rom_backed_d = 1'b0;
          case (host_a_i.opcode)
            Get: begin
              d_op_d  = AccessAckData;
              state_d = StResp;
              if (in_range) begin
                denied_d     = 1'b0;
                rom_backed_d = 1'b1;
                rom_req_o    = 1'b1;
                rom_addr_o   = start_idx_a;
              end else begin
                corrupt_d = 1'b1;
              end
            end
            Intent: begin
              d_op_d   = HintAck;
              beats_d  = CntW'(1);
              denied_d = 1'b0;
              state_d  = StResp;
            end
            ArithmeticData, LogicalData: begin
              d_op_d    = AccessAckData;
              corrupt_d = 1'b1;
              state_d   = multi_a ? StDrain : StResp;
            end
            default: begin
              d_op_d  = AccessAck;
              beats_d = CntW'(1);
              state_d = multi_a ? StDrain : StResp;
            end
          endcase
        end
      end
      StDrain: begin
        if (a_fire) begin
          drain_d = drain_q - CntW'(1);
          if (drain_q == CntW'(1)) state_d = StResp;
        end
      end
      StResp: begin
        if (d_fire) begin
          hold_valid_d = 1'b0;
          if (last_beat) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_nxt;
            if (rom_backed_q) begin
              rom_req_o  = 1'b1;
              rom_addr_o = next_idx;
            end
          end
        end else if (rom_backed_q && !hold_valid_q) begin
          // ROM output is only valid for one cycle; keep it while the host stalls.
          hold_valid_d = 1'b1;
          hold_d       = rom_rdata_i;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      d_op_q       <= AccessAck;
      size_q       <= '0;
      source_q     <= '0;
      denied_q     <= 1'b0;
      corrupt_q    <= 1'b0;
      rom_backed_q <= 1'b0;
      beats_q      <= '0;
      cnt_q        <= '0;
      drain_q      <= '0;
      start_q      <= '0;
      mask_q       <= '0;
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      d_op_q       <= d_op_d;
      size_q       <= size_d;
      source_q     <= source_d;
      denied_q     <= denied_d;
      corrupt_q    <= corrupt_d;
      rom_backed_q <= rom_backed_d;
      beats_q      <= beats_d;
      cnt_q        <= cnt_d;
      drain_q      <= drain_d;
      start_q      <= start_d;
      mask_q       <= mask_d;
      hold_valid_q <= hold_valid_d;
      hold_q       <= hold_d;
    end
  end

endmodule

// File: tb/tb_tl_rom_device.sv
// tb/tb_tl_rom_device.sv - table-driven and randomized bench for tl_rom_device against a transaction model
module tb_tl_rom_device;
  import tl_rom_device_pkg::*;

  localparam int unsigned RomDepth = 1024;
  localparam logic [55:0] ROM_BASE = 56'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_ready, d_valid, d_ready;
  logic        b_valid, c_ready, e_ready;
  logic        rom_req;
  logic [9:0]  rom_addr;
  logic [63:0] rom_rdata;
  tl_a_t       a_s;
  tl_d_t       d_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tl_rom_device #(.RomBase(ROM_BASE), .RomDepth(RomDepth)) dut (
    .clk_i(clk), .rst_i(rst),
    .host_a_valid_i(a_valid), .host_a_i(a_s), .host_a_ready_o(a_ready),
    .host_d_valid_o(d_valid), .host_d_o(d_s), .host_d_ready_i(d_ready),
    .host_b_valid_o(b_valid), .host_c_ready_o(c_ready), .host_e_ready_o(e_ready),
    .rom_req_o(rom_req), .rom_addr_o(rom_addr), .rom_rdata_i(rom_rdata)
  );

  function automatic logic [63:0] rom_word(input int unsigned i);
    return {16'hC0DE, 16'(i), (32'(i) * 32'h0001_0003) ^ 32'hDEAD_BEEF};
  endfunction

  // ROM macro: data is only meaningful the cycle after a request, garbage otherwise.
  always @(posedge clk) begin
    if (rom_req) rom_rdata <= rom_word(32'(rom_addr));
    else         rom_rdata <= {$urandom, $urandom};
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  tl_d_t held;
  bit    stalled = 0;
  always @(negedge clk) begin
    if (rst) begin
      stalled = 0;
    end else begin
      if (stalled) begin
        total++;
        if (!d_valid || d_s !== held) begin
          bad++;
          $display("FAIL d_payload_stable: got valid=%0b %0h expected %0h", d_valid, d_s, held);
        end
      end
      if (d_valid) begin
        total++;
        if (a_ready) begin
          bad++;
          $display("FAIL a_ready_during_d: got 1 expected 0");
        end
      end
      if (d_valid && !d_ready) begin
        total++;
        if (rom_req) begin
          bad++;
          $display("FAIL rom_req_while_stalled: got 1 expected 0");
        end
        stalled = 1;
        held    = d_s;
      end else begin
        stalled = 0;
      end
    end
  end

  typedef struct {
    logic [2:0]  dop;
    logic        denied;
    logic        corrupt;
    logic        rom;
    logic [63:0] data;
  } exp_t;
  exp_t exp_q[$];

  // Transaction-level reference: beats, opcodes and ROM words from plain byte arithmetic.
  task automatic model(input logic [2:0] op, input logic [3:0] size, input logic [55:0] addr,
                       output int n_a, output int reads);
    longint unsigned a, blk, base;
    int   n;
    bit   inr;
    exp_t e;
    a    = 64'(addr);
    blk  = 64'd1 << size;
    base = a - (a % blk);
    n    = (size <= 4'd3) ? 1 : int'(blk / 8);
    inr  = (a >= 64'(ROM_BASE)) && (a < 64'(ROM_BASE) + 64'(RomDepth) * 8);
    exp_q.delete();
    n_a   = 1;
    reads = 0;
    case (op)
      3'd4: begin
        for (int i = 0; i < n; i++) begin
          e.dop = 3'd1; e.denied = !inr; e.corrupt = !inr; e.rom = inr;
          e.data = inr ? rom_word(32'((base + 64'(i) * 8 - 64'(ROM_BASE)) / 8)) : 64'd0;
          exp_q.push_back(e);
        end
        reads = inr ? n : 0;
      end
      3'd5: begin
        e = '{dop: 3'd2, denied: 1'b0, corrupt: 1'b0, rom: 1'b0, data: 64'd0};
        exp_q.push_back(e);
      end
      3'd0, 3'd1: begin
        n_a = n;
        e = '{dop: 3'd0, denied: 1'b1, corrupt: 1'b0, rom: 1'b0, data: 64'd0};
        exp_q.push_back(e);
      end
      default: begin
        n_a = n;
        for (int i = 0; i < n; i++) begin
          e = '{dop: 3'd1, denied: 1'b1, corrupt: 1'b1, rom: 1'b0, data: 64'd0};
          exp_q.push_back(e);
        end
      end
    endcase
  endtask

  // mode 0: d_ready always high; 1: random d_ready; 2: stall beat 3 for 4 cycles.
  task automatic run_txn(input logic [2:0] op, input logic [3:0] size, input logic [55:0] addr,
                         input logic src, input int mode, output int n_d, output int reads);
    int n_a, exp_reads, beat_a, cyc, last_a_cyc, first_req, last_req, stall;
    bit first_d, afire;
    exp_t e;
    model(op, size, addr, n_a, exp_reads);
    a_s = '0;
    a_s.opcode  = tl_a_op_e'(op);
    a_s.size    = size;
    a_s.source  = src;
    a_s.address = addr;
    a_valid = 1'b1;
    d_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    beat_a = 0; n_d = 0; reads = 0; cyc = 0; last_a_cyc = -10;
    first_req = -1; last_req = -1; stall = 0; first_d = 0;
    while ((beat_a < n_a || n_d < exp_q.size()) && cyc < 200) begin
      @(negedge clk);
      afire = a_valid && a_ready;
      if (afire) last_a_cyc = cyc;
      if (rom_req) begin
        if (first_req < 0) first_req = cyc;
        last_req = cyc;
        reads++;
      end
      if (d_valid && !first_d) begin
        first_d = 1;
        check("first_d_latency", 64'(beat_a == n_a && cyc == last_a_cyc + 1), 64'd1);
      end
      if (d_valid && d_ready) begin
        if (n_d < exp_q.size()) begin
          e = exp_q[n_d];
          check("beat_hdr", 64'({d_s.opcode, d_s.param, d_s.size, d_s.source, d_s.sink, d_s.denied, d_s.corrupt}),
                64'({e.dop, 2'b00, size, src, 1'b0, e.denied, e.corrupt}));
          if (e.rom) check("beat_data", d_s.data, e.data);
        end
        n_d++;
      end
      @(posedge clk); #1;
      if (afire) begin
        beat_a++;
        if (beat_a == n_a) a_valid = 1'b0;
      end
      cyc++;
      if (mode == 1) d_ready = 1'($urandom_range(0, 1));
      else if (mode == 2 && n_d == 3 && stall < 4) begin d_ready = 1'b0; stall++; end
      else d_ready = 1'b1;
    end
    check("txn_timeout", 64'(cyc < 200), 64'd1);
    check("rom_reads", 64'(reads), 64'(exp_reads));
    if (mode == 0 && reads > 0) check("reads_consecutive", 64'(last_req - first_req + 1), 64'(reads));
    a_valid = 1'b0;
    d_ready = 1'b1;
    @(negedge clk);
    check("idle_after_burst", 64'(d_valid), 64'd0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  size;
    logic [55:0] addr;
    logic        src;
    int          mode;
    int          exp_n;
    int          exp_reads;
  } vec_t;

  initial begin
    vec_t vecs[12];
    int   n_d, reads, cnt, cyc;
    logic [2:0] op;
    logic [55:0] addr;
    bit   fire;

    vecs[0]  = '{3'd4, 4'd6, 56'h40,   1'b0, 0, 8, 8};
    vecs[1]  = '{3'd4, 4'd6, 56'h40,   1'b1, 2, 8, 8};
    vecs[2]  = '{3'd4, 4'd2, 56'h1C,   1'b1, 0, 1, 1};
    vecs[3]  = '{3'd0, 4'd4, 56'h80,   1'b0, 0, 1, 0};
    vecs[4]  = '{3'd4, 4'd6, 56'h2000, 1'b1, 0, 8, 0};
    vecs[5]  = '{3'd4, 4'd3, 56'h2000, 1'b0, 1, 1, 0};
    vecs[6]  = '{3'd5, 4'd6, 56'h0,    1'b1, 0, 1, 0};
    vecs[7]  = '{3'd2, 4'd5, 56'h100,  1'b0, 1, 4, 0};
    vecs[8]  = '{3'd1, 4'd3, 56'h8,    1'b1, 0, 1, 0};
    vecs[9]  = '{3'd3, 4'd0, 56'h3,    1'b0, 0, 1, 0};
    vecs[10] = '{3'd4, 4'd6, 56'h1FFF, 1'b1, 1, 8, 8};
    vecs[11] = '{3'd4, 4'd6, 56'h7F,   1'b0, 0, 8, 8};

    rst = 1'b1; a_valid = 1'b0; d_ready = 1'b0; a_s = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_a_ready", 64'(a_ready), 64'd0);
    check("reset_d_valid", 64'(d_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", 64'({a_ready, d_valid, rom_req, b_valid, c_ready, e_ready}), 64'b100011);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_txn(vecs[i].op, vecs[i].size, vecs[i].addr, vecs[i].src, vecs[i].mode, n_d, reads);
      check($sformatf("vec%0d_beats", i), 64'(n_d), 64'(vecs[i].exp_n));
      check($sformatf("vec%0d_reads", i), 64'(reads), 64'(vecs[i].exp_reads));
    end

    // Reset while beat 4 of an 8-beat Get is on the bus.
    a_s = '0; a_s.opcode = Get; a_s.size = 4'd6; a_s.address = 56'h40;
    a_valid = 1'b1; d_ready = 1'b1; cnt = 0; cyc = 0;
    while (cnt < 4 && cyc < 50) begin
      @(negedge clk);
      fire = a_valid && a_ready;
      if (d_valid && d_ready) cnt++;
      @(posedge clk); #1;
      if (fire) a_valid = 1'b0;
      cyc++;
    end
    check("rst_seq_beats", 64'(cnt), 64'd4);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_a_ready", 64'(a_ready), 64'd0);
    check("rst_mid_rom_req", 64'(rom_req), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (d_valid) cnt++;
      @(posedge clk); #1;
    end
    check("no_d_after_reset", 64'(cnt), 64'd0);
    run_txn(3'd4, 4'd6, 56'h40, 1'b1, 0, n_d, reads);
    check("post_reset_beats", 64'(n_d), 64'd8);

    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 7))
        0, 1, 2: op = 3'd4;
        3: op = 3'd0;
        4: op = 3'd1;
        5: op = 3'd2;
        6: op = 3'd3;
        default: op = 3'd5;
      endcase
      if ($urandom_range(0, 4) == 0) addr = 56'h2000 + 56'($urandom_range(0, 4095));
      else addr = 56'($urandom_range(0, 8191));
      run_txn(op, 4'($urandom_range(0, 6)), addr, 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 1)), n_d, reads);
      check("rand_beats", 64'(n_d), 64'(exp_q.size()));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
